// File: rtl/jsv_pkg.sv
// Shared types and constants for the Julia pixel engine: Q4.28 fixed point,
// escape radius, saturation limits and the frame FSM state encoding.
package jsv_pkg;

  localparam int FRAC_BITS = 28;

  typedef logic signed [31:0] fix_t;   // Q4.28
  typedef logic signed [39:0] wide_t;  // products after >>28, headroom for sums

  localparam wide_t ESCAPE_R2 = 40'sd4 <<< FRAC_BITS;
  localparam fix_t  FIX_MAX   = 32'sh7FFF_FFFF;
  localparam fix_t  FIX_MIN   = 32'sh8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_EMIT,
    S_NEXT,
    S_DONE
  } jpe_state_t;

  function automatic fix_t sat_fix(input wide_t v);
    if (v > wide_t'(FIX_MAX)) return FIX_MAX;
    if (v < wide_t'(FIX_MIN)) return FIX_MIN;
    return v[31:0];
  endfunction

endpackage

// File: rtl/julia_pixel_engine_if.sv
// Pixel output bus towards the SDRAM bitmap writer: draw/ready handshake
// carrying one (x, y, escape count) triple per transfer.
interface julia_pixel_engine_if;
  logic        sdram_draw;
  logic        sdram_ready;
  logic [15:0] sdram_x;
  logic [15:0] sdram_y;
  logic [7:0]  sdram_i;

  modport master (output sdram_draw, sdram_x, sdram_y, sdram_i, input sdram_ready);
  modport slave  (input sdram_draw, sdram_x, sdram_y, sdram_i, output sdram_ready);
endinterface

// File: rtl/julia_iter_core.sv
// One combinational step of z <- z^2 + c in Q4.28, with escape detection on
// the incoming z (|z|^2 > 4) and saturation of the next z.
module julia_iter_core
  import jsv_pkg::*;
(
  input  fix_t zr,
  input  fix_t zi,
  input  fix_t c_re,
  input  fix_t c_im,
  output fix_t zr_next,
  output fix_t zi_next,
  output logic escape
);

  logic signed [63:0] p_rr, p_ii, p_ri;
  wide_t rr, ii, ri, mag, re_sum, im_sum;

  assign p_rr = zr * zr;
  assign p_ii = zi * zi;
  assign p_ri = zr * zi;

  // |z| < 8 keeps every product below 2^34 after the shift, so 40 bits never wrap.
  assign rr = 40'(p_rr >>> FRAC_BITS);
  assign ii = 40'(p_ii >>> FRAC_BITS);
  assign ri = 40'(p_ri >>> FRAC_BITS);

  assign mag    = rr + ii;
  assign escape = mag > ESCAPE_R2;

  assign re_sum = rr - ii + wide_t'(c_re);
  assign im_sum = (ri <<< 1) + wide_t'(c_im);

  assign zr_next = sat_fix(re_sum);
  assign zi_next = sat_fix(im_sum);

endmodule

// File: rtl/julia_pixel_engine.sv
// Raster-scans an H_RES x V_RES frame, iterates the Julia recurrence per pixel
// and hands each escape count to the bitmap writer over a draw/ready handshake.
module julia_pixel_engine
  import jsv_pkg::*;
#(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  fix_t        c_re,
  input  fix_t        c_im,
  input  fix_t        x_min,
  input  fix_t        y_max,
  input  logic [31:0] step,
  output logic        busy,
  output logic        frame_done,
  julia_pixel_engine_if.master pix
);

  localparam logic [15:0] X_LAST   = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_RES - 1);
  localparam logic [7:0]  ITER_CAP = 8'(MAX_ITER);

  jpe_state_t  state_q, state_d;
  fix_t        c_re_q, c_im_q, x_min_q, re0_q, im0_q, zr_q, zi_q;
  fix_t        zr_next, zi_next;
  logic [31:0] step_q;
  logic [15:0] x_q, y_q;
  logic [7:0]  iter_q, i_q;
  logic        escape, last_pixel, iter_done;

  julia_iter_core u_core (
    .zr      (zr_q),
    .zi      (zi_q),
    .c_re    (c_re_q),
    .c_im    (c_im_q),
    .zr_next (zr_next),
    .zi_next (zi_next),
    .escape  (escape)
  );

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
  assign iter_done  = escape || (iter_q == ITER_CAP);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_INIT;  // start from any state aborts and restarts the frame
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_INIT: state_d = S_ITER;
        S_ITER: if (iter_done) state_d = S_EMIT;
        S_EMIT: if (pix.sdram_ready) state_d = S_NEXT;
        S_NEXT: state_d = last_pixel ? S_DONE : S_INIT;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      c_re_q  <= '0;
      c_im_q  <= '0;
      x_min_q <= '0;
      step_q  <= '0;
      re0_q   <= '0;
      im0_q   <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
      iter_q  <= '0;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (start) begin
      c_re_q  <= c_re;
      c_im_q  <= c_im;
      x_min_q <= x_min;
      step_q  <= step;
      re0_q   <= x_min;
      im0_q   <= y_max;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          zr_q   <= re0_q;
          zi_q   <= im0_q;
          iter_q <= '0;
        end
        S_ITER: begin
          if (iter_done) begin
            i_q <= iter_q;
          end else begin
            zr_q   <= zr_next;
            zi_q   <= zi_next;
            iter_q <= iter_q + 8'd1;
          end
        end
        S_NEXT: begin
          if (!last_pixel) begin
            if (x_q < X_LAST) begin
              x_q   <= x_q + 16'd1;
              re0_q <= re0_q + $signed(step_q);
            end else begin
              x_q   <= '0;
              re0_q <= x_min_q;
              y_q   <= y_q + 16'd1;
              im0_q <= im0_q - $signed(step_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix.sdram_draw = (state_q == S_EMIT);
  assign pix.sdram_x    = x_q;
  assign pix.sdram_y    = y_q;
  assign pix.sdram_i    = i_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign frame_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_julia_pixel_engine.sv
// Directed and randomized frames on a 4x2 engine, checked against a plain
// arithmetic model of the Julia escape count and the handshake timing rules.
module tb_julia_pixel_engine;
  import jsv_pkg::*;

  localparam int H = 4, V = 2, MI = 255, NPIX = H * V;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1;
  fix_t        c_re = '0, c_im = '0, x_min = '0, y_max = '0;
  logic [31:0] step = '0;
  logic        busy, frame_done;

  julia_pixel_engine_if pif ();
  assign pif.sdram_ready = ready;

  julia_pixel_engine #(.H_RES(H), .V_RES(V), .MAX_ITER(MI)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .start         (start),
    .c_re          (c_re),
    .c_im          (c_im),
    .x_min         (x_min),
    .y_max         (y_max),
    .step          (step),
    .busy          (busy),
    .frame_done    (frame_done),
    .pix           (pif.master)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int i; int cyc; } xfer_t;
  xfer_t xq[$];
  int    cyc = 0, done_count = 0, done_cyc = 0, start_cyc = 0;
  logic  done_busy = 1'b0;
  int    passed = 0, total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pif.sdram_draw && ready)
      xq.push_back('{int'(pif.sdram_x), int'(pif.sdram_y), int'(pif.sdram_i), cyc});
    if (frame_done) begin
      done_count++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic int ref_count(input longint zr0, input longint zi0,
                                   input longint cr, input longint ci);
    longint zr, zi, r2, i2, ri;
    zr = zr0;
    zi = zi0;
    for (int n = 0; n <= MI; n++) begin
      r2 = (zr * zr) >>> 28;
      i2 = (zi * zi) >>> 28;
      ri = (zr * zi) >>> 28;
      if (r2 + i2 > (64'sd4 <<< 28)) return n;
      if (n == MI) return n;
      zr = sat(r2 - i2 + cr);
      zi = sat(2 * ri + ci);
    end
    return MI;
  endfunction

  function automatic int ref_pixel(input int px, input int py, input fix_t cr, input fix_t ci,
                                   input fix_t xm, input fix_t ym, input logic [31:0] st);
    logic [31:0] re, im;
    re = xm + 32'(px) * st;
    im = ym - 32'(py) * st;
    return ref_count(longint'($signed(re)), longint'($signed(im)),
                     longint'(cr), longint'(ci));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input fix_t cr, input fix_t ci, input fix_t xm,
                             input fix_t ym, input logic [31:0] st);
    c_re = cr; c_im = ci; x_min = xm; y_max = ym; step = st;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs: the running frame must keep the latched copies.
    c_re = fix_t'($urandom); c_im = fix_t'($urandom);
    x_min = fix_t'($urandom); y_max = fix_t'($urandom); step = $urandom;
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int k = 0; k < 6000 && done_count == prev; k++) begin
      @(posedge clk); #1;
    end
    check({tag, " frame_done count"}, 64'(done_count - prev), 64'd1);
  endtask

  task automatic check_frame(input string tag, input fix_t cr, input fix_t ci, input fix_t xm,
                             input fix_t ym, input logic [31:0] st, input bit timing);
    int n, ei;
    n = xq.size();
    check({tag, " transfers"}, 64'(n), 64'(NPIX));
    for (int k = 0; k < n && k < NPIX; k++) begin
      ei = ref_pixel(k % H, k / H, cr, ci, xm, ym, st);
      check($sformatf("%s p%0d x", tag, k), 64'(xq[k].x), 64'(k % H));
      check($sformatf("%s p%0d y", tag, k), 64'(xq[k].y), 64'(k / H));
      check($sformatf("%s p%0d i", tag, k), 64'(xq[k].i), 64'(ei));
      if (timing && k > 0)
        check($sformatf("%s p%0d spacing", tag, k), 64'(xq[k].cyc - xq[k-1].cyc), 64'(ei + 4));
    end
    if (n > 0) check({tag, " done after last xfer"}, 64'(done_cyc - xq[n-1].cyc), 64'd2);
    check({tag, " busy low at done"}, 64'(done_busy), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  localparam fix_t ONE    = 32'sd268435456;
  localparam fix_t M_TWO  = -32'sd536870912;
  localparam fix_t M_2P5  = -32'sd671088640;

  initial begin
    fix_t        rc_re, rc_im, rx, ry, ac_re, ac_im;
    logic [31:0] rs;
    logic [15:0] sx, sy;
    logic [7:0]  si;
    int          base;
    bit          seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset draw",  64'(pif.sdram_draw), 64'd0);
    check("reset xyi",   64'({pif.sdram_x, pif.sdram_y, pif.sdram_i}), 64'd0);
    check("reset busy",  64'({busy, frame_done}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: c=0, x from -2.0 in steps of 1.0
    xq.delete(); base = done_count;
    pulse_start('0, '0, M_TWO, '0, ONE);
    @(negedge clk);
    check("A busy after start", 64'(busy), 64'd1);
    wait_done("A", base);
    check("A row0 i0", 64'(xq[0].i), 64'd1);
    check("A row0 i1", 64'(xq[1].i), 64'd255);
    check("A row0 i2", 64'(xq[2].i), 64'd255);
    check("A row0 i3", 64'(xq[3].i), 64'd255);
    check_frame("A", '0, '0, M_TWO, '0, ONE, 1'b1);

    // Frame B: first pixel escapes immediately
    xq.delete(); base = done_count;
    pulse_start('0, '0, M_2P5, '0, ONE);
    wait_done("B", base);
    check("B p0 immediate i", 64'(xq[0].i), 64'd0);
    check("B p0 latency", 64'(xq[0].cyc - start_cyc), 64'd3);
    check_frame("B", '0, '0, M_2P5, '0, ONE, 1'b1);

    // Randomized frames
    for (int r = 0; r < 3; r++) begin
      rc_re = fix_t'(int'($urandom_range(0, 32'h3FFF_FFFE)) - 32'sh1FFF_FFFF);
      rc_im = fix_t'(int'($urandom_range(0, 32'h3FFF_FFFE)) - 32'sh1FFF_FFFF);
      rx    = fix_t'(-int'($urandom_range(0, 32'h2000_0000)));
      ry    = fix_t'(int'($urandom_range(0, 32'h1000_0000)));
      rs    = $urandom_range(32'h0100_0000, 32'h0800_0000);
      xq.delete(); base = done_count;
      pulse_start(rc_re, rc_im, rx, ry, rs);
      wait_done($sformatf("R%0d", r), base);
      check_frame($sformatf("R%0d", r), rc_re, rc_im, rx, ry, rs, 1'b1);
    end

    // Backpressure: hold ready low for 10 cycles on the first pixel
    xq.delete(); base = done_count;
    ready = 1'b0;
    pulse_start('0, '0, M_TWO, '0, ONE);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = pif.sdram_draw;
    end
    check("BP draw seen", 64'(seen), 64'd1);
    sx = pif.sdram_x; sy = pif.sdram_y; si = pif.sdram_i;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("BP hold %0d", k),
            64'({pif.sdram_draw, pif.sdram_x, pif.sdram_y, pif.sdram_i}),
            64'({1'b1, sx, sy, si}));
    end
    check("BP no transfer while stalled", 64'(xq.size()), 64'd0);
    @(posedge clk); #1;
    ready = 1'b1;
    wait_done("BP", base);
    check_frame("BP", '0, '0, M_TWO, '0, ONE, 1'b0);

    // Abort at pixel (2,0) with draw high and ready low
    ac_re = 32'sh0400_0000; ac_im = -32'sh0200_0000;
    xq.delete(); base = done_count;
    ready = 1'b0;
    pulse_start(32'sh1000_0000, 32'sh0800_0000, M_TWO, ONE, ONE);
    seen = 1'b0;
    for (int k = 0; k < 1500 && !seen; k++) begin
      @(negedge clk);
      if (pif.sdram_draw) begin
        if (pif.sdram_x == 16'd2 && pif.sdram_y == 16'd0) seen = 1'b1;
        else begin
          @(posedge clk); #1 ready = 1'b1;
          @(posedge clk); #1 ready = 1'b0;
        end
      end
    end
    check("AB reached (2,0)", 64'(seen), 64'd1);
    check("AB pre-abort transfers", 64'(xq.size()), 64'd2);
    @(posedge clk); #1;
    pulse_start(ac_re, ac_im, M_TWO, ONE, ONE);
    @(negedge clk);
    check("AB draw dropped", 64'(pif.sdram_draw), 64'd0);
    check("AB busy", 64'(busy), 64'd1);
    check("AB no frame_done yet", 64'(done_count - base), 64'd0);
    xq.delete();
    ready = 1'b1;
    wait_done("AB", base);
    check_frame("AB", ac_re, ac_im, M_TWO, ONE, ONE, 1'b1);

    // Asynchronous reset mid-ITER
    pulse_start('0, '0, '0, '0, '0);
    repeat (20) @(posedge clk);
    #2;
    check("RST busy before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("RST outputs", 64'({pif.sdram_draw, pif.sdram_x, pif.sdram_y, pif.sdram_i,
                              busy, frame_done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    xq.delete(); base = done_count;
    repeat (300) @(posedge clk);
    #1;
    check("RST idle", 64'({busy, pif.sdram_draw}), 64'd0);
    check("RST no activity", 64'({xq.size(), done_count - base}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
